// File: rtl/in_port_fifo_pkg.sv
// rtl/in_port_fifo_pkg.sv - shared constants and types for the inbound port FIFO
//
// IRD_POS    : control-word bit that drives i_read (shared with the decoder)
// fifo_op_e  : per-cycle FIFO operation, encoded as {push, pop}
package in_port_fifo_pkg;

    // Position of the "read input port" bit inside the CPU control word.
    localparam int IRD_POS = 12;

    // Encoding matches the concatenation {push, pop} so it can be cast directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Next occupancy for a given operation; a simultaneous push and pop cancel.
    function automatic logic [7:0] next_count(input logic [7:0] cnt, input fifo_op_e op);
        logic [7:0] res;
        res = cnt;
        case (op)
            OP_PUSH: res = cnt + 8'd1;
            OP_POP:  res = cnt - 8'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/in_port_fifo_mem.sv
// rtl/in_port_fifo_mem.sv - DEPTH x WIDTH storage, one clocked write port, async read
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address (PTR_W)
//   wdata  in   write data (WIDTH)
//   raddr  in   read address (PTR_W)
//   rdata  out  combinational read data (WIDTH)
module in_port_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; the occupancy count masks stale data.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/in_port_fifo.sv
// rtl/in_port_fifo.sv - inbound peripheral FIFO: producer valid/ready push, CPU read/pop
//
// Optional feature macro: IN_PORT_FLAGS_EN (sticky o_underflow flag)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   clk_en       in   CPU clock enable, gates the pop side only
//   i_ext_valid  in   producer presents a word
//   i_ext_data   in   producer word (WIDTH)
//   o_ext_ready  out  registered ready, = not full
//   i_read       in   CPU control-word read/pop bit
//   o_data       out  head word to bus mux, 0 when empty (WIDTH)
//   o_empty      out  FIFO empty
//   o_full       out  FIFO full
//   o_count      out  entries held, 0..DEPTH (PTR_W+1)
//   o_underflow  out  sticky read-while-empty flag (0 unless IN_PORT_FLAGS_EN)
module in_port_fifo
    import in_port_fifo_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             i_ext_valid,
    input  logic [WIDTH-1:0] i_ext_data,
    output logic             o_ext_ready,
    input  logic             i_read,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [PTR_W:0]   o_count,
    output logic             o_underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             ready_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_word;
    fifo_op_e         op;

    assign o_empty     = (count == '0);
    assign o_full      = (count == FULL_CNT);
    assign o_count     = count;
    assign o_ext_ready = ready_q;

    // The full term is redundant with ready_q in normal operation but keeps the
    // FIFO safe if ready ever lags occupancy.
    assign push = i_ext_valid & ready_q & ~o_full;
    // A read while empty never pops; a same-cycle push only becomes visible next cycle.
    assign pop  = clk_en & i_read & ~o_empty;
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        logic [7:0] wide;
        wide       = next_count(8'(count), op);
        count_next = wide[PTR_W:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Ready follows the next occupancy, so it reasserts the cycle after a pop from full.
            ready_q <= (count_next != FULL_CNT);
        end
    end

    in_port_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (i_ext_data),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    assign o_data = o_empty ? '0 : head_word;

`ifdef IN_PORT_FLAGS_EN
    logic underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (clk_en & i_read & o_empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign o_underflow = underflow_q;
`else
    assign o_underflow = 1'b0;
`endif

endmodule
